// File: rtl/cache_line_mem_master.sv
// cache_line_mem_master: initiator side of the main-memory request/ready port.
// Turns one cache-line command (fill or writeback) into a 4-word memory burst.
//   Cache side : line_req/line_rw/line_addr/line_wdata in;
//                line_busy/line_done/line_rdata/line_error out.
//   Memory side: memory_request/memory_address/memory_rw/memory_data_in out;
//                memory_ready_to_interface/memory_data_out in.
// Optional macro MEM_MASTER_TIMEOUT_EN adds a per-phase watchdog with an ERR
// state. Without it, line_error is tied low and the block waits indefinitely.
module cache_line_mem_master #(
    parameter  int unsigned BEATS          = 4,
    parameter  int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned ADDR_W         = 32,
    localparam int unsigned WORD_W         = 32,
    localparam int unsigned LINE_W         = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_req,
    input  logic              line_rw,
    input  logic [ADDR_W-1:0] line_addr,
    input  logic [LINE_W-1:0] line_wdata,
    output logic              line_busy,
    output logic              line_done,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_error,
    output logic              memory_request,
    output logic [ADDR_W-1:0] memory_address,
    output logic              memory_rw,
    output logic [WORD_W-1:0] memory_data_in,
    input  logic              memory_ready_to_interface,
    input  logic [WORD_W-1:0] memory_data_out
);

    localparam int unsigned BEAT_W = 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

`ifdef MEM_MASTER_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_BEAT, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_BEAT, S_DONE
    } state_t;
`endif

    state_t              r_state;
    state_t              w_next_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [LINE_W-1:0]   r_wdata;
    logic [3*WORD_W-1:0] r_rbuf;
    logic                w_accept;
    logic                w_beat;
    logic                w_unused;

`ifdef MEM_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    assign w_unused = ^line_addr[3:0];
`else
    assign w_unused   = ^{line_addr[3:0], (TIMEOUT_CYCLES == 0)};
    assign line_error = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; the watchdog only fires when no progress is made
    always_comb begin
        w_next_state = r_state;
        w_accept     = (r_state == S_ISSUE) && memory_request && memory_ready_to_interface;
        w_beat       = (r_state == S_BEAT) && memory_ready_to_interface;
        unique case (r_state)
            S_IDLE:      if (line_req) w_next_state = S_ISSUE;
            S_ISSUE:     if (w_accept) w_next_state = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!memory_ready_to_interface) w_next_state = S_BEAT;
            S_BEAT:      if (w_beat && (r_beat == LAST_BEAT)) w_next_state = S_DONE;
            default:     w_next_state = S_IDLE;
        endcase
`ifdef MEM_MASTER_TIMEOUT_EN
        w_timeout = (r_to_cnt == TO_LAST) && !w_beat && (w_next_state == r_state) &&
                    (r_state inside {S_ISSUE, S_WAIT_BUSY, S_BEAT});
        if (w_timeout) w_next_state = S_ERR;
`endif
    end

    // Registered outputs and burst datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_busy      <= 1'b0;
            line_done      <= 1'b0;
            line_rdata     <= '0;
            memory_request <= 1'b0;
            memory_address <= '0;
            memory_rw      <= 1'b0;
            memory_data_in <= '0;
            r_beat         <= '0;
            r_wdata        <= '0;
            r_rbuf         <= '0;
        end else begin
            line_done <= (w_next_state == S_DONE);
            unique case (r_state)
                S_IDLE: begin
                    if (line_req) begin
                        memory_address <= {line_addr[ADDR_W-1:4], 4'h0};
                        memory_rw      <= line_rw;
                        r_wdata        <= line_wdata;
                        line_busy      <= 1'b1;
                        memory_request <= 1'b1;
                        memory_data_in <= line_rw ? line_wdata[WORD_W-1:0] : '0;
                        r_beat         <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_next_state != S_ISSUE) memory_request <= 1'b0;
                end
                S_WAIT_BUSY: begin
                    r_beat <= '0;
                end
                S_BEAT: begin
                    if (w_beat) begin
                        r_beat <= r_beat + BEAT_W'(1);
                        if (memory_rw) begin
                            // Present the next word; after the last beat the bus returns to 0
                            unique case (r_beat)
                                2'd0:    memory_data_in <= r_wdata[2*WORD_W-1:WORD_W];
                                2'd1:    memory_data_in <= r_wdata[3*WORD_W-1:2*WORD_W];
                                2'd2:    memory_data_in <= r_wdata[4*WORD_W-1:3*WORD_W];
                                default: memory_data_in <= '0;
                            endcase
                        end else begin
                            // Last word goes straight to line_rdata with the buffered three
                            unique case (r_beat)
                                2'd0:    r_rbuf[WORD_W-1:0]          <= memory_data_out;
                                2'd1:    r_rbuf[2*WORD_W-1:WORD_W]   <= memory_data_out;
                                2'd2:    r_rbuf[3*WORD_W-1:2*WORD_W] <= memory_data_out;
                                default: line_rdata <= {memory_data_out, r_rbuf};
                            endcase
                        end
                    end
                end
                default: begin
                    line_busy      <= 1'b0;
                    memory_data_in <= '0;
                end
            endcase
        end
    end

`ifdef MEM_MASTER_TIMEOUT_EN
    // Phase watchdog: restarts on every state change and every beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt   <= '0;
            line_error <= 1'b0;
        end else begin
            line_error <= (w_next_state == S_ERR);
            if ((w_next_state != r_state) || w_beat) r_to_cnt <= '0;
            else if (r_to_cnt != TO_LAST)            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`endif

endmodule
